// File: rtl/soc_design_dma_0_mem_write.sv
// DMA write master: pops words from a show-ahead FIFO and writes each one to consecutive addresses.
// Optional feature macro SOC_DESIGN_DMA_0_MEM_WRITE_TIMEOUT_EN aborts a write stalled for TIMEOUT cycles and sets err.
module soc_design_dma_0_mem_write #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_writedata,
    output logic              mem_write_n,
    input  logic              write_waitrequest,
    output logic              inc_write,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    if ((DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("DATA_W must be a multiple of 8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] remaining;
    logic             start;
    logic             pop;
    logic             accept;
    logic             abort;

    // Pops and writes are masked during reset so an interrupted transfer leaves no trace.
    assign start     = (state == IDLE) && clk_en && go;
    assign pop       = (state == WAIT_DATA) && clk_en && !fifo_empty && !reset;
    assign accept    = (state == WRITE) && clk_en && !write_waitrequest && !reset;
    assign fifo_rd   = pop;
    assign inc_write = accept;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef SOC_DESIGN_DMA_0_MEM_WRITE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;
    logic          err_q;

    assign abort = (state == WRITE) && clk_en && write_waitrequest
                   && (stall_cnt == TW'(TIMEOUT - 1));
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else if (clk_en) begin
            if (state == WRITE && write_waitrequest && !abort) begin
                stall_cnt <= stall_cnt + TW'(1);
            end else begin
                stall_cnt <= '0;
            end
            if (start) begin
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (pop) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    next_state = (remaining == LEN_W'(1)) ? DONE : WAIT_DATA;
                end else if (abort) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (clk_en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mem_write_n     <= 1'b1;
            write_address   <= '0;
            write_writedata <= '0;
            remaining       <= '0;
        end else if (clk_en) begin
            state       <= next_state;
            mem_write_n <= (next_state != WRITE);
            if (start) begin
                write_address <= start_addr;
                remaining     <= length;
            end
            if (pop) begin
                write_writedata <= fifo_rdata;
            end
            // Address wraps naturally at 2^ADDR_W.
            if (accept) begin
                write_address <= write_address + STRIDE;
                remaining     <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_design_dma_0_mem_write.sv
// Bench for soc_design_dma_0_mem_write: directed and randomized transfers checked against
// an address/data list built from the start address, the stride and the words handed to the FIFO.
module tb_soc_design_dma_0_mem_write;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_en = 1'b0;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_rdata = '0;
  logic              fifo_rd;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_writedata;
  logic              mem_write_n;
  logic              write_waitrequest = 1'b0;
  logic              inc_write;
  logic              busy;
  logic              done;
  logic              err;

  // clock/reset block
  always #5 clk = ~clk;

  soc_design_dma_0_mem_write #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .TIMEOUT(255)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .go               (go),
    .start_addr       (start_addr),
    .length           (length),
    .fifo_empty       (fifo_empty),
    .fifo_rdata       (fifo_rdata),
    .fifo_rd          (fifo_rd),
    .write_address    (write_address),
    .write_writedata  (write_writedata),
    .mem_write_n      (mem_write_n),
    .write_waitrequest(write_waitrequest),
    .inc_write        (inc_write),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  // scoreboard state
  int checks = 0;
  int passes = 0;
  logic [DATA_W-1:0] fifo_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int n_writes, n_pops, n_wr_low, cyc, done_cyc, busy_cycles;
  logic hold_empty = 1'b0;
  logic prev_stall = 1'b0;
  logic stall_chk = 1'b1;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  // stimulus knobs
  int stall_pct, empty_pct, off_pct, noise_pct;
  int stall_word, stall_n, empty_word, empty_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_knobs(input int sp, input int ep, input int op, input int np,
                           input int sw, input int sn, input int ew, input int en);
    stall_pct = sp; empty_pct = ep; off_pct = op; noise_pct = np;
    stall_word = sw; stall_n = sn; empty_word = ew; empty_n = en;
  endtask

  // One clock cycle: present FIFO head, observe outputs mid-cycle, update the model, advance.
  task automatic cycle();
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    #1;
    if (fifo_empty || !clk_en) check("fifo_rd_gated", fifo_rd, 1'b0);
    if (!clk_en) check("inc_write_gated", inc_write, 1'b0);
    if (n_pops == n_writes) check("no_write_without_data", mem_write_n, 1'b1);
    if (stall_chk && prev_stall) begin
      check("stall_addr", write_address, prev_addr);
      check("stall_data", write_writedata, prev_data);
      check("stall_wr_n", mem_write_n, 1'b0);
    end
    if (inc_write) begin
      check("wr_n_at_accept", mem_write_n, 1'b0);
      check("write_expected", exp_addr_q.size() != 0, 1'b1);
      if (exp_addr_q.size() != 0) begin
        check("wr_addr", write_address, exp_addr_q.pop_front());
        check("wr_data", write_writedata, exp_q.pop_front());
      end
      n_writes++;
    end
    if (fifo_rd) begin
      n_pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (busy) busy_cycles++;
    if (!mem_write_n) n_wr_low++;
    if (done && done_cyc < 0) done_cyc = cyc;
    prev_stall = !mem_write_n && !inc_write && !reset;
    prev_addr  = write_address;
    prev_data  = write_writedata;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_model();
    fifo_q.delete(); exp_addr_q.delete(); exp_q.delete();
    n_writes = 0; n_pops = 0; n_wr_low = 0; cyc = 0; done_cyc = -1; busy_cycles = 0;
    prev_stall = 1'b0;
  endtask

  // extra < 0 disables the exact cycle-count checks.
  task automatic run_xfer(input logic [ADDR_W-1:0] s, input int len, input int extra);
    int stall_left;
    int empty_left;
    logic [DATA_W-1:0] w;
    clear_model();
    stall_left = stall_n;
    empty_left = empty_n;
    for (int i = 0; i < len; i++) begin
      w = $urandom();
      fifo_q.push_back(w);
      exp_q.push_back(w);
      exp_addr_q.push_back(s + ADDR_W'(i * (DATA_W / 8)));
    end
    go = 1'b1; start_addr = s; length = LEN_W'(len);
    clk_en = 1'b1; write_waitrequest = 1'b0; hold_empty = 1'b0;
    cycle();
    go = 1'b0;
    while (done_cyc < 0 && cyc < 2000) begin
      clk_en = ($urandom_range(99) >= off_pct);
      write_waitrequest = ($urandom_range(99) < stall_pct);
      if (!mem_write_n && n_writes == stall_word && stall_left > 0) begin
        write_waitrequest = 1'b1;
        stall_left--;
      end
      hold_empty = ($urandom_range(99) < empty_pct);
      if (n_pops == empty_word && n_writes == empty_word && empty_left > 0) begin
        hold_empty = 1'b1;
        empty_left--;
      end
      go = ($urandom_range(99) < noise_pct);
      start_addr = $urandom();
      length = LEN_W'($urandom_range(9));
      cycle();
    end
    go = 1'b0;
    check("done_seen", done_cyc >= 0, 1'b1);
    check("write_count", n_writes, len);
    check("pop_count", n_pops, len);
    check("exp_drained", exp_addr_q.size(), 0);
    if (extra >= 0) begin
      check("done_latency", done_cyc, 2 * len + 1 + extra);
      check("busy_cycles", busy_cycles, 2 * len + 1 + extra);
    end
    clk_en = 1'b1; write_waitrequest = 1'b0; hold_empty = 1'b0;
    cycle();
    check("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    // reset held with clk_en low must still initialise everything
    reset = 1'b1; clk_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_wr_n", mem_write_n, 1'b1);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_inc_write", inc_write, 1'b0);
    check("rst_busy_done_err", {busy, done, err}, 3'b000);
    check("rst_addr", write_address, 0);
    check("rst_data", write_writedata, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    // four-word burst, no stalls
    set_knobs(0, 0, 0, 0, -1, 0, -1, 0);
    run_xfer(32'h0000_1000, 4, 0);
    // zero length
    run_xfer(32'h0000_2000, 0, 0);
    // three-cycle stall on the second word
    set_knobs(0, 0, 0, 0, 1, 3, -1, 0);
    run_xfer(32'h0000_4000, 4, 3);
    check("no_err_after_stall", err, 1'b0);
    // FIFO empty five cycles after the second word, clk_en toggling
    set_knobs(0, 0, 30, 0, -1, 0, 2, 5);
    run_xfer(32'h0000_5000, 5, -1);
    // address wrap
    set_knobs(0, 0, 0, 0, -1, 0, -1, 0);
    run_xfer(32'hFFFF_FFFC, 2, 0);

    // reset while a write is in flight
    clear_model();
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom());
    go = 1'b1; start_addr = 32'h0000_3000; length = 16'd3;
    clk_en = 1'b1; write_waitrequest = 1'b0; hold_empty = 1'b0;
    cycle();
    go = 1'b0;
    cycle();
    check("pre_reset_wr_n", mem_write_n, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_drop_write", inc_write, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    fifo_empty = 1'b0;
    #1;
    check("post_rst_idle", {busy, done, mem_write_n}, 3'b001);
    check("post_rst_no_pop", fifo_rd, 1'b0);
    check("post_rst_addr", write_address, 0);
    @(negedge clk);
    prev_stall = 1'b0;
    repeat (3) cycle();
    check("post_rst_pops", n_pops, 1);
    check("post_rst_writes", n_writes, 0);

    // randomized transfers with stalls, empty FIFO, clk_en gaps and ignored go pulses
    set_knobs(20, 20, 20, 10, -1, 0, -1, 0);
    for (int t = 0; t < 8; t++) begin
      run_xfer($urandom(), $urandom_range(1, 6), -1);
    end

`ifdef SOC_DESIGN_DMA_0_MEM_WRITE_TIMEOUT_EN
    // stuck waitrequest aborts after 255 stall cycles
    clear_model();
    stall_chk = 1'b0;
    fifo_q.push_back($urandom());
    go = 1'b1; start_addr = 32'h0000_6000; length = 16'd1;
    clk_en = 1'b1; write_waitrequest = 1'b1; hold_empty = 1'b0;
    cycle();
    go = 1'b0;
    while (done_cyc < 0 && cyc < 1000) cycle();
    check("to_done_cycle", done_cyc, 257);
    check("to_stall_cycles", n_wr_low, 255);
    check("to_no_write", n_writes, 0);
    check("to_err_set", err, 1'b1);
    write_waitrequest = 1'b0;
    cycle();
    check("to_err_sticky", err, 1'b1);
    go = 1'b1; length = 16'd0;
    cycle();
    go = 1'b0;
    check("to_err_cleared", err, 1'b0);
    cycle();
    stall_chk = 1'b1;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
